// File: rtl/mac_seq_if.sv
// Operand stream between the upstream producer and the MAC operand sequencer.
// The producer offers (iact, wght) pairs with in_valid; the sequencer accepts with in_ready.
interface mac_seq_if #(
    parameter int unsigned DATA_BITWIDTH = 8
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_BITWIDTH-1:0] in_iact;
    logic [DATA_BITWIDTH-1:0] in_wght;

    // Producer side
    modport master (
        output in_valid,
        output in_iact,
        output in_wght,
        input  in_ready
    );

    // Sequencer side
    modport slave (
        input  in_valid,
        input  in_iact,
        input  in_wght,
        output in_ready
    );

endinterface

// File: rtl/mac_seq.sv
// MAC operand sequencer.
// Frames KERNEL_SIZE operand pairs per window, appends the flush beat the pipelined MAC needs,
// pulses mac_dout_en, and flags with psum_valid the cycle the MAC's dout holds the window sum.
// Runs NUM_WINDOWS windows per accepted start, then pulses done.
// Optional build macro MAC_SEQ_PERF_EN enables the stall_cycles counter; otherwise it reads 0.
module mac_seq #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned KERNEL_SIZE   = 49,
    parameter int unsigned NUM_WINDOWS   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    mac_seq_if.slave                 in_bus,
    output logic                     mac_din_en,
    output logic                     mac_dout_en,
    output logic [DATA_BITWIDTH-1:0] mac_iact,
    output logic [DATA_BITWIDTH-1:0] mac_wght,
    output logic                     psum_valid,
    output logic [15:0]              win_idx,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              stall_cycles
);

    localparam int unsigned BeatW = $clog2(KERNEL_SIZE + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(KERNEL_SIZE - 1);
    localparam logic [15:0] LastWin = 16'(NUM_WINDOWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StFlush,
        StDump,
        StWait1,
        StWait2,
        StNext
    } state_e;

    state_e           state;
    logic [BeatW-1:0] beat_cnt;
    logic             in_ready;
    logic             handshake;

    assign in_bus.in_ready = in_ready;
    assign handshake       = in_bus.in_valid && in_ready;

    // Sequencer FSM with registered outputs. Because every output is registered, what a state
    // drives becomes visible one cycle later: the last data beat shows while in FLUSH, the
    // flush beat while in DUMP, mac_dout_en while in WAIT1 and psum_valid while in NEXT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            beat_cnt    <= '0;
            win_idx     <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            psum_valid  <= 1'b0;
            mac_din_en  <= 1'b0;
            mac_dout_en <= 1'b0;
            mac_iact    <= '0;
            mac_wght    <= '0;
        end else begin
            // Single-cycle strobes default low; operands hold unless overwritten.
            mac_din_en  <= 1'b0;
            mac_dout_en <= 1'b0;
            psum_valid  <= 1'b0;
            done        <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StFeed;
                        beat_cnt <= '0;
                        win_idx  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                StFeed: begin
                    if (handshake) begin
                        mac_din_en <= 1'b1;
                        mac_iact   <= in_bus.in_iact;
                        mac_wght   <= in_bus.in_wght;
                        beat_cnt   <= beat_cnt + 1'b1;
                        if (beat_cnt == LastBeat) begin
                            state    <= StFlush;
                            in_ready <= 1'b0;
                        end
                    end
                end

                StFlush: begin
                    // Zero-operand beat: pushes the last product into the accumulator and
                    // leaves the MAC operand registers cleared for the next window.
                    mac_din_en <= 1'b1;
                    mac_iact   <= '0;
                    mac_wght   <= '0;
                    state      <= StDump;
                end

                StDump: begin
                    mac_dout_en <= 1'b1;
                    state       <= StWait1;
                end

                StWait1: begin
                    state <= StWait2;
                end

                StWait2: begin
                    psum_valid <= 1'b1;
                    state      <= StNext;
                end

                StNext: begin
                    if (win_idx == LastWin) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        win_idx  <= win_idx + 16'd1;
                        beat_cnt <= '0;
                        in_ready <= 1'b1;
                        state    <= StFeed;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef MAC_SEQ_PERF_EN
    logic [15:0] stall_cnt;

    // Count FEED cycles with no offered pair; saturating, cleared on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == StIdle && start) begin
            stall_cnt <= '0;
        end else if (state == StFeed && !in_bus.in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule
